// File: rtl/dmem_responder.sv
// Data-side SRAM responder for the core req/gnt/valid port: in-order, fixed-latency responses.
// Optional `define DMEM_STALL_EN adds LFSR-driven grant stalls for protocol stress.
`timescale 1ns/1ps
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS  = 4096,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int unsigned RESP_LATENCY = 1,
  parameter logic [15:0] STALL_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_be,
  output logic        data_gnt,
  output logic [31:0] data_rdata,
  output logic        data_valid,
  output logic        data_error
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

  logic [31:0]             mem [DEPTH_WORDS];
  logic [31:0]             mem_q;
  logic [IDX_W-1:0]        idx;
  logic                    addr_err;
  logic                    stall;
  logic                    accept;
  logic                    hit_q;
  logic [31:0]             word0;
  logic [RESP_LATENCY-1:0] pipe_valid;
  logic [RESP_LATENCY-1:0] pipe_err;

`ifdef DMEM_STALL_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11; free-running regardless of traffic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= STALL_SEED;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign data_gnt = data_req & ~stall & ~reset;
  assign accept   = data_req & data_gnt;

  assign idx      = IDX_W'((data_addr - BASE_ADDR) >> 2);
  assign addr_err = (data_addr[1:0] != 2'b00)
                  | (data_addr < BASE_ADDR)
                  | ({1'b0, data_addr} >= END_ADDR);

  // NOTE: the array and its read register carry no reset so they map onto plain SRAM;
  // the reset-cleared hit_q below masks mem_q, so stale data never reaches the port.
  always_ff @(posedge clk) begin
    if (accept && !addr_err) begin
      if (data_wr) begin
        for (int b = 0; b < 4; b++)
          if (data_be[b]) mem[idx][8*b +: 8] <= data_wdata[8*b +: 8];
      end else begin
        mem_q <= mem[idx];
      end
    end
  end

  // NOTE: non-blocking assignments give every stage its pre-edge value, so the loop
  // below is a true shift register and a same-edge write never leaks into the read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_valid <= '0;
      pipe_err   <= '0;
      hit_q      <= 1'b0;
    end else begin
      pipe_valid[0] <= accept;
      pipe_err[0]   <= accept & addr_err;
      hit_q         <= accept & ~data_wr & ~addr_err;
      for (int s = 1; s < RESP_LATENCY; s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
        pipe_err[s]   <= pipe_err[s-1];
      end
    end
  end

  assign word0 = hit_q ? mem_q : 32'h0;

  if (RESP_LATENCY == 1) begin : g_lat1
    assign data_rdata = word0;
  end else begin : g_latn
    logic [31:0] rdata_sr [1:RESP_LATENCY-1];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int s = 1; s < RESP_LATENCY; s++) rdata_sr[s] <= '0;
      end else begin
        rdata_sr[1] <= word0;
        for (int s = 2; s < RESP_LATENCY; s++) rdata_sr[s] <= rdata_sr[s-1];
      end
    end

    assign data_rdata = rdata_sr[RESP_LATENCY-1];
  end

  assign data_valid = pipe_valid[RESP_LATENCY-1];
  assign data_error = pipe_err[RESP_LATENCY-1];

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: latency-1 and latency-3 instances, directed vectors.
`timescale 1ns/1ps
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req1, wr1, gnt1, valid1, err1;
  logic [31:0] addr1, wdata1, rdata1;
  logic [3:0]  be1;
  logic        req3, wr3, gnt3, valid3, err3;
  logic [31:0] addr3, wdata3, rdata3;
  logic [3:0]  be3;

  dmem_responder #(.RESP_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .data_req(req1), .data_wr(wr1), .data_addr(addr1),
    .data_wdata(wdata1), .data_be(be1), .data_gnt(gnt1), .data_rdata(rdata1),
    .data_valid(valid1), .data_error(err1));

  dmem_responder #(.RESP_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .data_req(req3), .data_wr(wr3), .data_addr(addr3),
    .data_wdata(wdata3), .data_be(be3), .data_gnt(gnt3), .data_rdata(rdata3),
    .data_valid(valid3), .data_error(err3));

  typedef struct {
    logic        err;
    logic        chk;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   v3_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic m_stall;
`ifdef DMEM_STALL_EN
  logic [15:0] m_lfsr;
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end
  assign m_stall = (m_lfsr[1:0] == 2'b00);
`else
  assign m_stall = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop one expectation per response strobe; idle cycles must be all-zero.
  always @(negedge clk) begin
    if (valid1) begin
      if (q1.size() == 0) check("dut1_extra_valid", 32'(valid1), 32'h0);
      else begin
        e1 = q1.pop_front();
        if (e1.chk) check("dut1_rdata", rdata1, e1.rdata);
        check("dut1_error", 32'(err1), 32'(e1.err));
        check("dut1_resp_cycle", 32'(cyc), 32'(e1.cyc));
      end
    end else begin
      check("dut1_idle_rdata", rdata1, 32'h0);
      check("dut1_idle_error", 32'(err1), 32'h0);
    end
  end

  always @(negedge clk) begin
    if (valid3) begin
      v3_seen++;
      if (q3.size() == 0) check("dut3_extra_valid", 32'(valid3), 32'h0);
      else begin
        e3 = q3.pop_front();
        if (e3.chk) check("dut3_rdata", rdata3, e3.rdata);
        check("dut3_error", 32'(err3), 32'(e3.err));
        check("dut3_resp_cycle", 32'(cyc), 32'(e3.cyc));
      end
    end else begin
      check("dut3_idle_rdata", rdata3, 32'h0);
      check("dut3_idle_error", 32'(err3), 32'h0);
    end
  end

  task automatic drive(input int d, input logic req, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    if (d == 1) begin req1 = req; wr1 = wr; addr1 = addr; wdata1 = wdata; be1 = be; end
    else        begin req3 = req; wr3 = wr; addr3 = addr; wdata3 = wdata; be3 = be; end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic issue(input int d, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic exp_err, input logic chk, input logic [31:0] exp_rdata);
    int   waits = 0;
    exp_t e;
    drive(d, 1'b1, wr, addr, wdata, be);
    @(negedge clk);
    while (!(d == 1 ? gnt1 : gnt3) && waits < 64) begin
      waits++;
      @(negedge clk);
    end
`ifdef DMEM_STALL_EN
    if (waits == 64) check("gnt_timeout", 32'(waits), 32'h0);
`else
    check("gnt_same_cycle", 32'(waits), 32'h0);
`endif
    if (waits < 64) begin
      e.err = exp_err; e.chk = chk; e.rdata = exp_rdata;
      e.cyc = cyc + (d == 1 ? 1 : 3);
      if (d == 1) q1.push_back(e); else q3.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int d);
    drive(d, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic drain();
    int t = 0;
    while ((q1.size() != 0 || q3.size() != 0) && t < 100) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk); #1;
    check("drain_q1", 32'(q1.size()), 32'h0);
    check("drain_q3", 32'(q3.size()), 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    idle(1);
    idle(3);
    #1 reset = 1'b1;
    drive(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) begin
      @(negedge clk);
      check("reset_gnt", 32'(gnt1), 32'h0);
      check("reset_valid", 32'(valid1), 32'h0);
    end
    reset = 1'b0;
    idle(1);
    @(posedge clk); #1;

    // Read of uninitialised word: only timing and error flag are meaningful.
    issue(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    idle(1);
    @(posedge clk); #1;

    issue(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 32'h0);
    issue(1, 1'b0, 32'h10, 32'h0,        4'h0, 1'b0, 1'b1, 32'hDEADBEEF);

    issue(1, 1'b1, 32'h20, 32'h11223344, 4'hF,    1'b0, 1'b1, 32'h0);
    issue(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, 1'b1, 32'h0);
    issue(1, 1'b0, 32'h20, 32'h0,        4'h0,    1'b0, 1'b1, 32'h11BB33DD);
    issue(1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0,    1'b0, 1'b1, 32'h0);
    issue(1, 1'b0, 32'h20, 32'h0,        4'h0,    1'b0, 1'b1, 32'h11BB33DD);

    issue(1, 1'b1, 32'h0,    32'h12345678, 4'hF, 1'b0, 1'b1, 32'h0);
    issue(1, 1'b0, 32'h3,    32'h0,        4'h0, 1'b1, 1'b1, 32'h0);
    issue(1, 1'b0, 32'h4000, 32'h0,        4'h0, 1'b1, 1'b1, 32'h0);
    issue(1, 1'b1, 32'h4000, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b1, 32'h0);
    issue(1, 1'b1, 32'h12,   32'h55555555, 4'hF, 1'b1, 1'b1, 32'h0);
    issue(1, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 1'b1, 32'h12345678);
    issue(1, 1'b0, 32'h10,   32'h0,        4'h0, 1'b0, 1'b1, 32'hDEADBEEF);
    issue(1, 1'b1, 32'h3FFC, 32'hCAFEF00D, 4'hF, 1'b0, 1'b1, 32'h0);
    issue(1, 1'b0, 32'h3FFC, 32'h0,        4'h0, 1'b0, 1'b1, 32'hCAFEF00D);
    issue(1, 1'b0, 32'hFFFFFFFC, 32'h0,    4'h0, 1'b1, 1'b1, 32'h0);
    idle(1);
    drain();

    // Request held for 200 cycles: grants follow the stall model, one response each.
    drive(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int i = 0; i < 200; i++) begin
      exp_t e;
      @(negedge clk);
      check("held_gnt", 32'(gnt1), 32'(!m_stall));
      if (!m_stall) begin
        e.err = 1'b0; e.chk = 1'b1; e.rdata = 32'h12345678; e.cyc = cyc + 1;
        q1.push_back(e);
      end
    end
    @(posedge clk); #1;
    idle(1);
    drain();

    // Latency-3 instance: fill, then eight back-to-back reads.
    for (int i = 0; i < 8; i++)
      issue(3, 1'b1, 32'(4 * i), 32'hC0DE0000 + 32'(i * 32'h111), 4'hF, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 8; i++)
      issue(3, 1'b0, 32'(4 * i), 32'h0, 4'h0, 1'b0, 1'b1, 32'hC0DE0000 + 32'(i * 32'h111));
    idle(3);
    drain();

    // Two reads in flight when reset hits: neither may ever be answered.
    issue(3, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0, 1'b1, 32'hC0DE0111);
    issue(3, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, 1'b1, 32'hC0DE0222);
    idle(3);
    reset = 1'b1;
    q3.delete();
    v3_seen = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("no_resp_after_reset", 32'(v3_seen), 32'h0);

    issue(3, 1'b0, 32'h1C, 32'h0, 4'h0, 1'b0, 1'b1, 32'hC0DE0777);
    idle(3);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
